// File: rtl/ldpc_pkg.sv
// Shared definitions for the rate-5/6 QC-LDPC layered decoder: supported
// lifting sizes, prototype geometry, the skip-entry encoding, the block
// descriptor carried to the check-node datapath and the sequencer states.
package ldpc_pkg;

  localparam int Z_27 = 27;
  localparam int Z_54 = 54;
  localparam int Z_81 = 81;

  localparam int LDPC_ROWS = 4;
  localparam int LDPC_COLS = 24;

  // Widest descriptor fields over all supported Z and the rate-5/6 geometry.
  localparam int SHIFT_W_MAX = 7;
  localparam int DESC_ROW_W  = 2;
  localparam int DESC_COL_W  = 5;

  typedef struct packed {
    logic [DESC_ROW_W-1:0]  row;
    logic [DESC_COL_W-1:0]  col;
    logic [SHIFT_W_MAX-1:0] shift;
    logic                   last;
  } blk_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_LWAIT,
    ST_NEXT,
    ST_DONE
  } sched_state_e;

  // A zero block is stored as all-ones in the low w bits of the shift field.
  function automatic logic [SHIFT_W_MAX-1:0] skip_value(input int w);
    logic [SHIFT_W_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < SHIFT_W_MAX; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/proto_layer_scheduler_if.sv
// Block-descriptor stream from the layer scheduler to the check-node
// datapath, plus the datapath's per-layer write-back acknowledge.
interface proto_layer_scheduler_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 24,
  parameter int WIDTH = 6
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic             blk_valid;
  logic             blk_ready;
  logic [RW-1:0]    blk_row;
  logic [CW-1:0]    blk_col;
  logic [WIDTH-1:0] blk_shift;
  logic             blk_last;
  logic             layer_ack;

  modport master (
    output blk_valid, blk_row, blk_col, blk_shift, blk_last,
    input  blk_ready, layer_ack
  );

  modport slave (
    input  blk_valid, blk_row, blk_col, blk_shift, blk_last,
    output blk_ready, layer_ack
  );
endinterface

// File: rtl/proto_entry_skid.sv
// Hold register of the layer scanner. Keeps the next descriptor to be
// emitted while the scanner looks ahead at the following ROM entry; a
// parked lookahead is loaded over the hold entry on the handshake.
module proto_entry_skid
  import ldpc_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear,
  input  logic      load,
  input  blk_desc_t load_desc,
  input  logic      mark_last,
  output logic      full,
  output blk_desc_t hold
);

  blk_desc_t hold_q, hold_d;
  logic      full_q, full_d;

  // Next hold content: clear wins, then load, then tagging the entry as last.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (clear) begin
      hold_d = '0;
      full_d = 1'b0;
    end else if (load) begin
      hold_d = load_desc;
      full_d = 1'b1;
    end else if (mark_last && full_q) begin
      hold_d.last = 1'b1;
    end
  end

  // Hold register with asynchronous clear so outputs return to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign full = full_q;
  assign hold = hold_q;

endmodule

// File: rtl/proto_layer_scheduler.sv
// Layered-decoding sequencer: walks the prototype matrix row by row each
// iteration, drops zero blocks, streams (row, col, shift) descriptors to the
// check-node datapath and waits for a write-back acknowledge per layer.
// Optional feature macro: PROTO_SCHED_EARLY_STOP_EN (early_stop terminates
// the decode at an iteration boundary; otherwise early_stop is ignored).
module proto_layer_scheduler
  import ldpc_pkg::*;
#(
  parameter int Z        = 54,
  parameter int ROWS     = LDPC_ROWS,
  parameter int COLS     = LDPC_COLS,
  parameter int WIDTH    = $clog2(Z),
  parameter int ADDRW    = $clog2(ROWS*COLS),
  parameter int MAX_ITER = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic                          early_stop,
  output logic [ADDRW-1:0]              rom_addr,
  input  logic [WIDTH-1:0]              rom_data,
  proto_layer_scheduler_if.master       blk,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_cnt
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int IW = $clog2(MAX_ITER+1);

  if (!(Z == Z_27 || Z == Z_54 || Z == Z_81) || MAX_ITER < 1) begin : g_bad_cfg
    $error("proto_layer_scheduler: unsupported Z or MAX_ITER");
  end

  sched_state_e  state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [IW-1:0] iter_q, iter_d;

  logic      hold_full;
  blk_desc_t hold;
  logic      sk_clear, sk_load, sk_mark_last;
  blk_desc_t sk_desc;
  logic      valid_c;
  logic      es_term;

`ifdef PROTO_SCHED_EARLY_STOP_EN
  assign es_term = early_stop;
`else
  logic unused_early_stop;
  assign unused_early_stop = early_stop;
  assign es_term = 1'b0;
`endif

  logic entry_skip;
  logic at_last_col;
  logic at_last_row;
  assign entry_skip  = (rom_data == WIDTH'(skip_value(WIDTH)));
  assign at_last_col = (col_q == CW'(COLS-1));
  assign at_last_row = (row_q == RW'(ROWS-1));

  // Next-state, scanner position and hold-register control.
  always_comb begin
    logic advance;
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    iter_d       = iter_q;
    sk_clear     = 1'b0;
    sk_load      = 1'b0;
    sk_mark_last = 1'b0;
    valid_c      = 1'b0;
    advance      = 1'b0;
    sk_desc       = '0;
    sk_desc.row   = DESC_ROW_W'(row_q);
    sk_desc.col   = DESC_COL_W'(col_q);
    sk_desc.shift = SHIFT_W_MAX'(rom_data);
    sk_desc.last  = at_last_col;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SCAN;
          row_d    = '0;
          col_d    = '0;
          iter_d   = '0;
          sk_clear = 1'b1;
        end
      end
      ST_SCAN: begin
        if (entry_skip) begin
          advance = 1'b1;
        end else if (!hold_full) begin
          sk_load = 1'b1;
          advance = 1'b1;
        end else begin
          // Scanner parked on a valid lookahead: hold entry is offered.
          valid_c = 1'b1;
          if (blk.blk_ready) begin
            sk_load = 1'b1;
            advance = 1'b1;
          end
        end
        if (advance) begin
          if (at_last_col) begin
            state_d      = ST_DRAIN;
            sk_mark_last = 1'b1;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!hold_full) begin
          state_d = ST_NEXT;
        end else begin
          valid_c = 1'b1;
          if (blk.blk_ready) begin
            sk_clear = 1'b1;
            state_d  = ST_LWAIT;
          end
        end
      end
      ST_LWAIT: begin
        if (blk.layer_ack) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        col_d = '0;
        if (!at_last_row) begin
          row_d   = row_q + RW'(1);
          state_d = ST_SCAN;
        end else begin
          iter_d = iter_q + IW'(1);
          if ((iter_q + IW'(1)) == IW'(MAX_ITER) || es_term) begin
            state_d = ST_DONE;
          end else begin
            row_d   = '0;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and scanner position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      iter_q  <= iter_d;
    end
  end

  proto_entry_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (sk_clear),
    .load      (sk_load),
    .load_desc (sk_desc),
    .mark_last (sk_mark_last),
    .full      (hold_full),
    .hold      (hold)
  );

  assign rom_addr      = ADDRW'(ADDRW'(row_q) * ADDRW'(COLS) + ADDRW'(col_q));
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done          = (state_q == ST_DONE);
  assign iter_cnt      = iter_q;
  assign blk.blk_valid = valid_c;
  assign blk.blk_row   = RW'(hold.row);
  assign blk.blk_col   = CW'(hold.col);
  assign blk.blk_shift = WIDTH'(hold.shift);
  assign blk.blk_last  = hold.last;

endmodule

// File: tb/tb_proto_layer_scheduler.sv
// Scoreboard bench for proto_layer_scheduler: each decode's full descriptor
// stream is predicted from the ROM contents and queued at start; a monitor
// pops and compares on every handshake and checks stall stability.
module tb_proto_layer_scheduler;
  localparam int Z        = 54;
  localparam int ROWS     = 4;
  localparam int COLS     = 24;
  localparam int WIDTH    = 6;
  localparam int ADDRW    = 7;
  localparam int MAX_ITER = 2;
  localparam logic [WIDTH-1:0] SKIP = '1;
`ifdef PROTO_SCHED_EARLY_STOP_EN
  localparam bit ES_EN = 1'b1;
`else
  localparam bit ES_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]       row;
    logic [4:0]       col;
    logic [WIDTH-1:0] shift;
    logic             last;
  } exp_t;

  logic clk, rst_n, start, busy, done, early_stop;
  logic [ADDRW-1:0] rom_addr;
  logic [WIDTH-1:0] rom_data;
  logic [1:0]       iter_cnt;
  logic [WIDTH-1:0] rom [0:(1<<ADDRW)-1];
  logic             ready_all;
  exp_t             sb[$];
  int               exp_iters;
  int               checks = 0;
  int               errors = 0;

  proto_layer_scheduler_if #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) bif ();

  proto_layer_scheduler #(
    .Z(Z), .ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .ADDRW(ADDRW), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .early_stop (early_stop),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .blk        (bif),
    .iter_cnt   (iter_cnt)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: every non-skip entry of every row, each iteration, with the
  // last flag on the highest non-skip column of the row.
  function automatic void build_expected();
    exp_t e;
    int   lastc;
    exp_iters = (ES_EN && early_stop) ? 1 : MAX_ITER;
    for (int it = 0; it < exp_iters; it++) begin
      for (int r = 0; r < ROWS; r++) begin
        lastc = -1;
        for (int c = 0; c < COLS; c++) if (rom[r*COLS+c] != SKIP) lastc = c;
        for (int c = 0; c < COLS; c++) begin
          if (rom[r*COLS+c] != SKIP) begin
            e.row = 2'(r); e.col = 5'(c); e.shift = rom[r*COLS+c]; e.last = (c == lastc);
            sb.push_back(e);
          end
        end
      end
    end
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, bif.blk_valid, 0);
    chk({tag, "_last"}, bif.blk_last, 0);
    chk({tag, "_rowcolshift"}, {bif.blk_row, bif.blk_col, bif.blk_shift}, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_iter_cnt"}, iter_cnt, 0);
  endtask

  task automatic issue_start();
    build_expected();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("rom_addr_first_cycle", rom_addr, 0);
    chk("no_valid_first_cycle", bif.blk_valid, 0);
  endtask

  task automatic run_decode();
    bit got;
    issue_start();
    got = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (c == 15) start = 1'b1;
      if (c == 16) start = 1'b0;
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    start = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no_done required=done pending=%0d", sb.size());
      sb.delete();
    end else begin
      chk("iter_cnt_at_done", iter_cnt, exp_iters);
      chk("all_descs_seen", sb.size(), 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
    end
  endtask

  // Ready generator: always-ready or a 50% random stall pattern.
  initial begin
    bif.blk_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bif.blk_ready = ready_all ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Datapath model: acknowledges a layer a few cycles after its last beat,
  // and occasionally pulses a stray acknowledge while a layer is streaming.
  initial begin
    bif.layer_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bif.blk_valid && bif.blk_ready && bif.blk_last) begin
        int d;
        d = $urandom_range(0, 3);
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1 bif.layer_ack = 1'b1;
        @(posedge clk);
        #1 bif.layer_ack = 1'b0;
      end else if (rst_n && bif.blk_valid && !bif.blk_last && $urandom_range(0, 7) == 0) begin
        bif.layer_ack = 1'b1;
        @(posedge clk);
        #1 bif.layer_ack = 1'b0;
      end
    end
  end

  // Monitor: compare each accepted descriptor and check stall stability.
  initial begin
    bit   stall;
    exp_t saved, cur, e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        cur = {bif.blk_row, bif.blk_col, bif.blk_shift, bif.blk_last};
        if (stall) begin
          chk("stall_valid_held", bif.blk_valid, 1);
          chk("stall_outputs_stable", cur, saved);
        end
        if (bif.blk_valid && bif.blk_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_desc actual=%0h required=none", cur);
          end else begin
            e = sb.pop_front();
            chk("desc", cur, e);
          end
          stall = 1'b0;
        end else if (bif.blk_valid) begin
          stall = 1'b1;
          saved = cur;
        end else begin
          stall = 1'b0;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; early_stop = 1'b0; ready_all = 1'b1;
    for (int i = 0; i < (1<<ADDRW); i++) rom[i] = SKIP;
    repeat (3) @(posedge clk); #1;
    check_reset("por");
    rst_n = 1'b1;

    // Dense matrix, always ready.
    for (int i = 0; i < ROWS*COLS; i++) rom[i] = WIDTH'($urandom_range(0, Z-1));
    run_decode();

    // Skip patterns: row1 cols 3/20, row2 cols 22/23, row3 all skip.
    ready_all = 1'b0;
    for (int i = 0; i < ROWS*COLS; i++) rom[i] = WIDTH'($urandom_range(0, Z-1));
    rom[1*COLS+3] = SKIP; rom[1*COLS+20] = SKIP;
    rom[2*COLS+22] = SKIP; rom[2*COLS+23] = SKIP;
    for (int c = 0; c < COLS; c++) rom[3*COLS+c] = SKIP;
    run_decode();

    // First row all skip, last row only column 0, row 1 only column 23.
    for (int i = 0; i < ROWS*COLS; i++) rom[i] = WIDTH'($urandom_range(0, Z-1));
    for (int c = 0; c < COLS; c++) begin
      rom[c] = SKIP;
      if (c != 0) rom[3*COLS+c] = SKIP;
      if (c != COLS-1) rom[1*COLS+c] = SKIP;
    end
    run_decode();

    // Random sparse matrices with random stalls.
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < ROWS*COLS; i++)
        rom[i] = ($urandom_range(0, 4) == 0) ? SKIP : WIDTH'($urandom_range(0, Z-1));
      run_decode();
    end

    // Early stop held high across the first iteration boundary.
    early_stop = 1'b1;
    run_decode();
    early_stop = 1'b0;

    // Reset mid-layer, then a clean decode.
    issue_start();
    repeat (40) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("mid_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_decode();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/proto_layer_scheduler.md
# proto_layer_scheduler

- Layered-decoding sequencer for the rate-5/6 QC-LDPC decoder; walks the 4×24 prototype matrix row by row, once per iteration.
- Drives the ROM address, drops zero-block ("-") entries, and streams non-skip (row, col, shift) block descriptors to the check-node datapath over a valid/ready handshake.
- Waits for a per-layer acknowledge, counts iterations, and terminates on the iteration limit or early stop.
- Sits between decoder top-level control and the prototype ROM / CNU pipeline.

## Interface
Parameters:
- Z, 54: lifting size; legal values are 27, 54 and 81.
- ROWS, 4: prototype rows (layers).
- COLS, 24: prototype columns.
- WIDTH, $clog2(Z): shift-value width.
- ADDRW, $clog2(ROWS*COLS): ROM address width.
- MAX_ITER, 8: iteration limit, ≥1.

Ports:
- clk  in  1  clock; single clock domain, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin decode; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at termination.
- early_stop  in  1  syndrome-zero flag from the datapath.
- rom_addr  out  ADDRW  ROM address = row*COLS+col.
- rom_data  in  WIDTH  combinational ROM read of rom_addr.
- blk_valid  out  1  descriptor valid.
- blk_ready  in  1  datapath accepts.
- blk_row  out  $clog2(ROWS)  layer index.
- blk_col  out  $clog2(COLS)  column index.
- blk_shift  out  WIDTH  circulant shift, 0..Z-1.
- blk_last  out  1  last non-skip block of the layer.
- layer_ack  in  1  datapath finished write-back of the current layer.
- iter_cnt  out  $clog2(MAX_ITER+1)  completed iterations.

## Operation
Skip rule:
- A ROM entry equal to all-ones of WIDTH is a skip; it is never emitted.

States:
- IDLE -> SCAN on start. Clears row, col, iter_cnt and the hold register.
- SCAN: the scanner reads rom_addr.
  - Skip entry: col advances.
  - Valid entry with hold empty: the entry is loaded into hold; col advances.
  - Valid entry with hold full: the scanner parks; the parked entry is the lookahead.
  - col passing COLS-1: hold is marked last; go to DRAIN.
- DRAIN: emit the hold entry with blk_last=1. On handshake go to LWAIT. If hold is empty (all-skip row), go directly to NEXT.
- LWAIT: wait for layer_ack, then NEXT.
- NEXT:
  - row < ROWS-1: row+1, col 0, -> SCAN.
  - row == ROWS-1: iter_cnt+1. If iter_cnt+1 == MAX_ITER or (early stop, see Configuration): -> DONE. Otherwise row 0, -> SCAN.
- DONE: done=1 for one cycle, busy drops, -> IDLE.

Handshake:
- blk_valid = hold full AND (scanner parked OR state DRAIN).
- On blk_valid && blk_ready: if the scanner is parked, the parked entry moves into hold and the scanner advances.
- Outputs stay stable while blk_valid && !blk_ready. blk_valid is never withdrawn without a handshake.

Boundary rules:
- start while busy: ignored.
- layer_ack outside LWAIT: ignored.
- early_stop: sampled only in NEXT at row ROWS-1.

## Timing
- Reset values: busy 0, done 0, blk_valid 0, blk_last 0, blk_row 0, blk_col 0, blk_shift 0, rom_addr 0, iter_cnt 0; state IDLE.
- rst_n low mid-decode aborts immediately with no done pulse.
- start accepted at cycle T: rom_addr = row 0 col 0 during T+1. The first blk_valid comes no earlier than T+2.
- Dense row: one descriptor per cycle while blk_ready=1.
- Each skip entry adds one scan cycle.
- Layer turnaround: the LWAIT->NEXT->SCAN overhead is 2 cycles after layer_ack before the next row's first ROM read.
- done asserts the cycle after NEXT decides to terminate.

## Configuration
- PROTO_SCHED_EARLY_STOP_EN defined: early_stop=1 at an iteration boundary terminates the decode; iter_cnt holds the completed count.
- Undefined: the early_stop port exists but is ignored; decoding always runs MAX_ITER iterations.

## Structure
- Shared package ldpc_pkg holds:
  - supported-Z constants;
  - ROWS/COLS for rate 5/6;
  - skip-value function (all-ones of WIDTH);
  - block-descriptor struct (row, col, shift, last);
  - state enum.
- The ROM is instantiated by the parent, not inside this block.
- One sub-module, proto_entry_skid: the hold register plus park/advance logic.

## Test plan
- All rows dense (no skips), blk_ready=1, MAX_ITER=2 -> 192 descriptors with blk_col 0..23 per row. blk_last only at col 23. done pulses once; iter_cnt=2.
- Row 1 with skips at cols 3 and 20 -> those columns absent. blk_last on the last non-skip column. 22 beats for that row.
- Row 2 with skips at cols 22 and 23 -> blk_last on col 21.
- Row 3 all skip -> no descriptors and no LWAIT for that row; the iteration still completes.
- blk_ready toggled randomly (50%) -> no descriptor lost or duplicated; outputs stable while stalled.
- early_stop=1 at the end of iteration 1 -> done, iter_cnt=1 with PROTO_SCHED_EARLY_STOP_EN; iter_cnt=MAX_ITER without it.
- rst_n asserted mid-layer -> all outputs return to reset values; a new start then runs a clean decode.
